// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state type and default width for the serial adder
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int ADDER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational 1-bit full adder built from two half adders and an OR
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  assign s1 = a ^ b;
  assign c1 = a & b;
  assign s  = s1 ^ cin;
  assign c2 = s1 & cin;
  assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder with start/busy/done handshake
// Optional subtract mode (sub port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cell_s;
  logic             cell_co;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1 - cin, so the borrow-in folds into the initial carry.
  assign b_load     = sub ? ~b : b;
  assign carry_load = cin ^ sub;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  fa_cell u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (cell_s),
    .co  (cell_co)
  );

  assign accept = start && (state != SHIFT);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  // Shift/insert written without part-selects so WIDTH=1 elaborates cleanly.
  always_comb begin
    r_next            = r_sr >> 1;
    r_next[WIDTH-1]   = cell_s;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last)  state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b_load;
      carry <= carry_load;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      r_sr  <= r_next;
      carry <= cell_co;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= r_next;
        cout <= cell_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH=8
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Scoreboard: every done pulse consumes one expected {cout, sum}.
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (busy && done) begin
        n_fail++;
        $display("FAIL busy_done_overlap busy=%0b done=%0b required not both", busy, done);
      end
      if (done) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done got sum=%h cout=%0b required no done", sum, cout);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({cout, sum} !== e) begin
            n_fail++;
            $display("FAIL result got cout=%0b sum=%h required cout=%0b sum=%h",
                     cout, sum, e[8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic is);
    logic [8:0] e;
    if (is) begin
      e = {1'b0, ia} - {1'b0, ib} - {8'd0, ic};
      e[8] = ~e[8];
    end else begin
      e = {1'b0, ia} + {1'b0, ib} + {8'd0, ic};
    end
    exp_q.push_back(e);
    a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout got no done required done within 30 cycles", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state got busy=%0b done=%0b cout=%0b sum=%h required all 0",
               busy, done, cout, sum);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    issue(8'h0F, 8'h01, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL add_busy_cycle%0d got busy=%0b done=%0b required busy=1 done=0", k, busy, done);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL add_done_cycle9 got done=%0b required 1", done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_corners();
    logic [16:0] vec[5];
    vec[0] = {8'hFF, 8'h01, 1'b1};
    vec[1] = {8'h00, 8'h00, 1'b0};
    vec[2] = {8'hFF, 8'hFF, 1'b1};
    vec[3] = {8'hAA, 8'h55, 1'b0};
    vec[4] = {8'h80, 8'h80, 1'b0};
    foreach (vec[i]) begin
      issue(vec[i][16:9], vec[i][8:1], vec[i][0], 1'b0);
      wait_done("corner");
    end
  endtask

  task automatic test_busy_protect();
    int extra = 0;
    issue(8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_protect");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL busy_protect_extra_done got %0d required 0", extra);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int k = 0;
    bit seen = 0;
    issue(8'h20, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    exp_q.push_back(9'h002);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen || k != 9) begin
      n_fail++;
      $display("FAIL back_to_back_latency got %0d cycles (seen=%0b) required 9", k, seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    issue(8'h55, 8'h66, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_checks++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got busy=%0b done=%0b cout=%0b sum=%h required all 0",
               busy, done, cout, sum);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_done got %0d pulses required 0", dones);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'h03, 8'h04, 1'b0, 1'b0);
    wait_done("after_reset");
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    issue(8'h07, 8'h05, 1'b0, 1'b1);
    wait_done("sub_pos");
    issue(8'h05, 8'h07, 1'b0, 1'b1);
    wait_done("sub_neg");
    issue(8'h10, 8'h01, 1'b0, 1'b0);
    wait_done("sub_off");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_corners();
    test_busy_protect();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_results got %0d required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that sits around a single full-adder cell. It accepts two WIDTH-bit operands plus carry-in, feeds them LSB-first through the cell one bit per clock with a registered carry, and presents the WIDTH-bit sum and carry-out with a start/busy/done handshake. It is the sequential stage built on the team's full-adder cell, trading area for latency in multi-bit arithmetic paths.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range WIDTH ≥ 1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when the block is in IDLE or DONE
- a  input  WIDTH  operand A, captured on an accepted start
- b  input  WIDTH  operand B, captured on an accepted start
- cin  input  1  carry-in, captured on an accepted start
- sub  input  1  subtract mode, captured on an accepted start; present only with SERIAL_ADDER_SUB_EN
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when sum/cout update
- sum  output  WIDTH  registered result; holds its value until the next done
- cout  output  1  registered final carry; holds its value until the next done

## Operation
- The design has one clock domain. Reset is asynchronous and active-low. Every register clears immediately on rst_n=0: state=IDLE, busy=0, done=0, sum=0, cout=0, and the internal shift registers, counter and carry all go to 0.
- States:
  - IDLE: if start=1, capture a, b and cin into the shift registers and carry register, clear the bit counter, then go to SHIFT.
  - SHIFT: on each cycle, the cell computes a_sr[0] + b_sr[0] + carry.
    - The sum bit shifts into the MSB of the result shift register, which shifts right.
    - a_sr and b_sr shift right.
    - carry takes the cell's carry-out.
    - The counter increments.
    - When the counter reaches WIDTH-1, the cycle copies the result shift register and carry to sum/cout and goes to DONE.
  - DONE: done=1 for this single cycle. If start=1, behave as IDLE with start (back-to-back operation); otherwise go to IDLE.
- start is ignored while in SHIFT. There is no queuing, and the operands in flight are unaffected.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1), with no overflow flag.
- The bit counter is $clog2(WIDTH) bits wide, with a minimum of 1 bit. When WIDTH=1, SHIFT lasts exactly one cycle.
- sum/cout never show partial results. They change only on the edge that enters DONE.

## Timing
- Cycle 0 is the cycle in which start is sampled high in IDLE or DONE.
- busy is high in cycles 1..WIDTH.
- done is high, and the new sum/cout are visible, in cycle WIDTH+1.
- Latency from start to done is WIDTH+1 clocks. Throughput is one operation per WIDTH+1 clocks when start is held or re-asserted in DONE.
- busy and done are never high in the same cycle.
- If rst_n is asserted during SHIFT, the operation is aborted with no done pulse. The first start after reset deassertion is accepted normally.

## Configuration
- Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - The sub port exists.
  - When sub=1 is captured, b is loaded bitwise inverted and the initial carry = cin XOR 1. The result is {cout, sum} = a − b − cin in two's complement: cout=1 means no borrow, cout=0 means borrow.
  - When sub=0, behaviour is identical to the add-only build.
- Undefined:
  - The sub port is absent.
  - The block is add-only.
  - No inversion logic is synthesised.

## Structure
- Shared package adder_pkg contains:
  - the state typedef (IDLE, SHIFT, DONE as a 2-bit enum);
  - the default width constant ADDER_WIDTH_DEFAULT = 8.
- One sub-module, fa_cell: a combinational 1-bit full adder (a, b, cin → s, co) built from two half adders and an OR gate. It is instantiated once in serial_adder.
- The FSM, counter, shift registers and carry register live in serial_adder.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold rst_n=0 mid-clock → busy=0, done=0, sum=8'h00 and cout=0 immediately, with no clock edge required.
- Add: a=8'h0F, b=8'h01, cin=0, start pulse → busy for 8 cycles, then done in cycle 9 with sum=8'h10 and cout=0.
- Carry-out: a=8'hFF, b=8'h01, cin=1 → sum=8'h01, cout=1 in cycle 9. Run all four corners {00,00,0}, {FF,FF,1}, {AA,55,0} and {80,80,0}, expecting {00,0}, {FF,1}, {FF,0} and {00,1}.
- Busy protection and back-to-back:
  - Start with 8'h12+8'h34, then assert start with 8'hFF+8'hFF in cycle 3 → first result is 8'h46, cout=0.
  - Hold start=1 in the DONE cycle with 8'h01+8'h01 → second done 9 cycles later with 8'h02.
- Reset mid-operation: assert rst_n=0 in cycle 4 of SHIFT → no done pulse and outputs are 0. After release, 8'h03+8'h04 gives 8'h07.
- With SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=8'h07, b=8'h05, cin=0 → sum=8'h02, cout=1.
  - sub=1, a=8'h05, b=8'h07, cin=0 → sum=8'hFE, cout=0.
